cpu6502_seq: RTL and testbench

//  Parametrised, handshaked successor to the first-generation 6502 core. A multi-cycle sequencer

---
 rtl/cpu6502_pkg.sv | 116 +++++++++++
 rtl/cpu6502_alu_flags.sv | 52 +++++
 rtl/cpu6502_seq.sv | 216 +++++++++++++++++++++
 tb/tb_cpu6502_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502-subset sequencer: state encoding, opcodes,
// ALU operations, flag bit positions and the opcode decoder.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_OPLO  = 3'd1,
    ST_OPHI  = 3'd2,
    ST_FIX   = 3'd3,
    ST_READ  = 3'd4,
    ST_EXEC  = 3'd5,
    ST_HALT  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    MODE_IMPL, MODE_IMM, MODE_ZP, MODE_ZPX, MODE_ABS, MODE_ABSX, MODE_BAD
  } mode_e;

  typedef enum logic [2:0] {
    ALU_PASS, ALU_ADC, ALU_SBC, ALU_AND, ALU_ORA, ALU_EOR, ALU_INC, ALU_DEC
  } alu_op_e;

  typedef enum logic [2:0] {
    SEL_A, SEL_X, SEL_Y, SEL_M, SEL_NONE
  } sel_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_TYA     = 8'h98;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_DEX     = 8'hCA;
  localparam logic [7:0] OP_INY     = 8'hC8;
  localparam logic [7:0] OP_DEY     = 8'h88;
  localparam logic [7:0] OP_SEC     = 8'h38;
  localparam logic [7:0] OP_CLC     = 8'h18;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_SBC_IMM = 8'hE9;
  localparam logic [7:0] OP_AND_IMM = 8'h29;
  localparam logic [7:0] OP_ORA_IMM = 8'h09;
  localparam logic [7:0] OP_EOR_IMM = 8'h49;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDA_ZPX = 8'hB5;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_LDA_ABX = 8'hBD;

  typedef struct packed {
    mode_e   mode;
    alu_op_e alu;
    sel_e    a_sel;
    sel_e    b_sel;
    sel_e    dst;
    logic    upd_nz;
    logic    upd_cv;
    logic    set_c;
    logic    clr_c;
  } decode_t;

  function automatic mode_e op_mode(input logic [7:0] op);
    case (op)
      OP_TAX, OP_TXA, OP_TAY, OP_TYA, OP_INX, OP_DEX,
      OP_INY, OP_DEY, OP_SEC, OP_CLC, OP_NOP:            return MODE_IMPL;
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_ADC_IMM,
      OP_SBC_IMM, OP_AND_IMM, OP_ORA_IMM, OP_EOR_IMM:    return MODE_IMM;
      OP_LDA_ZP:                                         return MODE_ZP;
      OP_LDA_ZPX:                                        return MODE_ZPX;
      OP_LDA_ABS:                                        return MODE_ABS;
      OP_LDA_ABX:                                        return MODE_ABSX;
      default:                                           return MODE_BAD;
    endcase
  endfunction

  function automatic decode_t decode(input logic [7:0] op);
    decode_t d;
    d       = '0;
    d.mode  = op_mode(op);
    d.alu   = ALU_PASS;
    d.a_sel = SEL_A;
    d.b_sel = SEL_M;
    d.dst   = SEL_NONE;
    case (op)
      OP_LDA_IMM, OP_LDA_ZP, OP_LDA_ZPX, OP_LDA_ABS, OP_LDA_ABX: begin
        d.dst = SEL_A; d.upd_nz = 1'b1;
      end
      OP_LDX_IMM: begin d.dst = SEL_X; d.upd_nz = 1'b1; end
      OP_LDY_IMM: begin d.dst = SEL_Y; d.upd_nz = 1'b1; end
      OP_ADC_IMM: begin d.alu = ALU_ADC; d.dst = SEL_A; d.upd_nz = 1'b1; d.upd_cv = 1'b1; end
      OP_SBC_IMM: begin d.alu = ALU_SBC; d.dst = SEL_A; d.upd_nz = 1'b1; d.upd_cv = 1'b1; end
      OP_AND_IMM: begin d.alu = ALU_AND; d.dst = SEL_A; d.upd_nz = 1'b1; end
      OP_ORA_IMM: begin d.alu = ALU_ORA; d.dst = SEL_A; d.upd_nz = 1'b1; end
      OP_EOR_IMM: begin d.alu = ALU_EOR; d.dst = SEL_A; d.upd_nz = 1'b1; end
      OP_TAX: begin d.b_sel = SEL_A; d.dst = SEL_X; d.upd_nz = 1'b1; end
      OP_TXA: begin d.b_sel = SEL_X; d.dst = SEL_A; d.upd_nz = 1'b1; end
      OP_TAY: begin d.b_sel = SEL_A; d.dst = SEL_Y; d.upd_nz = 1'b1; end
      OP_TYA: begin d.b_sel = SEL_Y; d.dst = SEL_A; d.upd_nz = 1'b1; end
      OP_INX: begin d.alu = ALU_INC; d.a_sel = SEL_X; d.dst = SEL_X; d.upd_nz = 1'b1; end
      OP_DEX: begin d.alu = ALU_DEC; d.a_sel = SEL_X; d.dst = SEL_X; d.upd_nz = 1'b1; end
      OP_INY: begin d.alu = ALU_INC; d.a_sel = SEL_Y; d.dst = SEL_Y; d.upd_nz = 1'b1; end
      OP_DEY: begin d.alu = ALU_DEC; d.a_sel = SEL_Y; d.dst = SEL_Y; d.upd_nz = 1'b1; end
      OP_SEC: d.set_c = 1'b1;
      OP_CLC: d.clr_c = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu6502_alu_flags.sv
// Combinational ALU: computes the result plus candidate N/Z/C/V flags;
// the sequencer decides which of them are committed.
module alu_flags
  import cpu6502_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e             op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                cin,
  output logic [DATA_W-1:0]   result,
  output logic                n,
  output logic                z,
  output logic                c,
  output logic                v
);

  localparam logic [DATA_W-1:0] ONE = 1;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] m_eff;
  logic [DATA_W-1:0] v_bits;

  always_comb begin
    sum    = '0;
    m_eff  = b;
    result = b;
    c      = cin;
    v_bits = '0;
    case (op)
      ALU_ADC, ALU_SBC: begin
        // SBC is ADC of the inverted operand; carry-in acts as "no borrow"
        m_eff  = (op == ALU_SBC) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, m_eff} + {{DATA_W{1'b0}}, cin};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
        v_bits = (a ^ result) & (m_eff ^ result);
      end
      ALU_AND: result = a & b;
      ALU_ORA: result = a | b;
      ALU_EOR: result = a ^ b;
      ALU_INC: result = a + ONE;
      ALU_DEC: result = a - ONE;
      default: result = b;
    endcase
    v = v_bits[DATA_W-1];
    n = result[DATA_W-1];
    z = (result == '0);
  end

endmodule

// File: rtl/cpu6502_seq.sv
// Multi-cycle 6502-subset sequencer with a wait-stated read-only memory port,
// N/V/Z/C flags, indexed addressing with page-cross fix-up and halt on unknown opcodes.
module cpu6502_seq
  import cpu6502_pkg::*;
#(
  parameter int                  DATA_W   = 8,
  parameter logic [2*DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0]   SP_RESET = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [2*DATA_W-1:0]  mem_addr,
  output logic                 mem_rd,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ready,
  output logic                 instr_done,
  output logic                 halted,
  output logic [DATA_W-1:0]    a_out,
  output logic [DATA_W-1:0]    x_out,
  output logic [DATA_W-1:0]    y_out,
  output logic [3:0]           p_out,
  output logic [2*DATA_W-1:0]  pc_out,
  output logic [2:0]           state_out
);

  localparam int ADDR_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [DATA_W-1:0] ONE_D = 1;

  state_e              state_reg,   state_next;
  logic [DATA_W-1:0]   a_reg,       a_next;
  logic [DATA_W-1:0]   x_reg,       x_next;
  logic [DATA_W-1:0]   y_reg,       y_next;
  logic [3:0]          p_reg,       p_next;
  logic [ADDR_W-1:0]   pc_reg,      pc_next;
  logic [DATA_W-1:0]   opcode_reg,  opcode_next;
  logic [DATA_W-1:0]   operand_reg, operand_next;
  logic [ADDR_W-1:0]   ea_reg,      ea_next;
  // Stack pointer is architectural state for future stack opcodes; nothing here changes it.
  logic [DATA_W-1:0]   sp_reg;

  decode_t             dec;
  mode_e               fetch_mode;
  logic [DATA_W:0]     idx_sum;
  logic [DATA_W-1:0]   alu_a, alu_b, alu_res;
  logic                alu_n, alu_z, alu_c, alu_v;

  assign dec        = decode(opcode_reg[7:0]);
  assign fetch_mode = op_mode(mem_rdata[7:0]);
  assign idx_sum    = {1'b0, operand_reg} + {1'b0, x_reg};

  always_comb begin
    alu_a = a_reg;
    case (dec.a_sel)
      SEL_X:   alu_a = x_reg;
      SEL_Y:   alu_a = y_reg;
      default: alu_a = a_reg;
    endcase
    alu_b = operand_reg;
    case (dec.b_sel)
      SEL_A:   alu_b = a_reg;
      SEL_X:   alu_b = x_reg;
      SEL_Y:   alu_b = y_reg;
      default: alu_b = operand_reg;
    endcase
  end

  alu_flags #(.DATA_W(DATA_W)) u_alu (
    .op     (dec.alu),
    .a      (alu_a),
    .b      (alu_b),
    .cin    (p_reg[FLAG_C]),
    .result (alu_res),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c),
    .v      (alu_v)
  );

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    p_next       = p_reg;
    pc_next      = pc_reg;
    opcode_next  = opcode_reg;
    operand_next = operand_reg;
    ea_next      = ea_reg;
    mem_rd       = 1'b0;
    mem_addr     = pc_reg;
    instr_done   = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          opcode_next = mem_rdata;
          pc_next     = pc_reg + ONE_A;
          case (fetch_mode)
            MODE_BAD:  state_next = ST_HALT;
            MODE_IMPL: state_next = ST_EXEC;
            default:   state_next = ST_OPLO;
          endcase
        end
      end
      ST_OPLO: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          operand_next = mem_rdata;
          pc_next      = pc_reg + ONE_A;
          case (dec.mode)
            MODE_IMM: state_next = ST_EXEC;
            MODE_ZP: begin
              ea_next    = {{DATA_W{1'b0}}, mem_rdata};
              state_next = ST_READ;
            end
            MODE_ZPX: begin
              // zero-page index wraps within page zero
              ea_next    = {{DATA_W{1'b0}}, mem_rdata + x_reg};
              state_next = ST_READ;
            end
            default: state_next = ST_OPHI;
          endcase
        end
      end
      ST_OPHI: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          pc_next = pc_reg + ONE_A;
          if (dec.mode == MODE_ABSX) begin
            ea_next    = {mem_rdata, idx_sum[DATA_W-1:0]};
            state_next = idx_sum[DATA_W] ? ST_FIX : ST_READ;
          end else begin
            ea_next    = {mem_rdata, operand_reg};
            state_next = ST_READ;
          end
        end
      end
      ST_FIX: begin
        ea_next    = {ea_reg[ADDR_W-1:DATA_W] + ONE_D, ea_reg[DATA_W-1:0]};
        state_next = ST_READ;
      end
      ST_READ: begin
        mem_rd   = 1'b1;
        mem_addr = ea_reg;
        if (mem_ready) begin
          operand_next = mem_rdata;
          state_next   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_done = 1'b1;
        state_next = ST_FETCH;
        case (dec.dst)
          SEL_A:   a_next = alu_res;
          SEL_X:   x_next = alu_res;
          SEL_Y:   y_next = alu_res;
          default: ;
        endcase
        if (dec.upd_nz) begin
          p_next[FLAG_N] = alu_n;
          p_next[FLAG_Z] = alu_z;
        end
        if (dec.upd_cv) begin
          p_next[FLAG_C] = alu_c;
          p_next[FLAG_V] = alu_v;
        end
        if (dec.set_c) p_next[FLAG_C] = 1'b1;
        if (dec.clr_c) p_next[FLAG_C] = 1'b0;
      end
      default: ;
    endcase

    // No bus activity or retire pulse while reset is asserted
    if (!reset) begin
      mem_rd     = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_FETCH;
      a_reg       <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      p_reg       <= '0;
      pc_reg      <= RESET_PC;
      sp_reg      <= SP_RESET;
      opcode_reg  <= '0;
      operand_reg <= '0;
      ea_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      p_reg       <= p_next;
      pc_reg      <= pc_next;
      sp_reg      <= sp_reg;
      opcode_reg  <= opcode_next;
      operand_reg <= operand_next;
      ea_reg      <= ea_next;
    end
  end

  assign halted    = (state_reg == ST_HALT);
  assign a_out     = a_reg;
  assign x_out     = x_reg;
  assign y_out     = y_reg;
  assign p_out     = p_reg;
  assign pc_out    = pc_reg;
  assign state_out = state_reg;

endmodule

// File: tb/tb_cpu6502_seq.sv
// Directed bench for cpu6502_seq: expected retire results are queued per program
// and checked against the DUT whenever an instruction retires.
module tb_cpu6502_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        instr_done;
  logic        halted;
  logic [7:0]  a_out, x_out, y_out;
  logic [3:0]  p_out;
  logic [15:0] pc_out;
  logic [2:0]  state_out;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int cyc_now  = 0;

  typedef struct {
    string       tag;
    logic [7:0]  a, x, y;
    logic [3:0]  p;
    logic [15:0] pc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  cpu6502_seq #(.DATA_W(8), .RESET_PC(16'h0000), .SP_RESET(8'hFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .instr_done (instr_done),
    .halted     (halted),
    .a_out      (a_out),
    .x_out      (x_out),
    .y_out      (y_out),
    .p_out      (p_out),
    .pc_out     (pc_out),
    .state_out  (state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input string tag, input logic [7:0] a, input logic [7:0] x,
                              input logic [7:0] y, input logic [3:0] p,
                              input logic [15:0] pc, input int cyc);
    exp_t t;
    t.tag = tag; t.a = a; t.x = x; t.y = y; t.p = p; t.pc = pc; t.cyc = cyc;
    sb.push_back(t);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
  endtask

  // Wait for all queued instructions to retire, then hold reset for two cycles.
  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
    chk("drain_queue_empty", sb.size(), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard consumer: one entry per retired instruction.
  always @(posedge clk) begin
    if (reset !== 1'b1) begin
      cyc_cnt = 0;
    end else begin
      cyc_cnt++;
      if (instr_done === 1'b1) begin
        cyc_now = cyc_cnt;
        cyc_cnt = 0;
        #1;
        chk("retire_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("retire %s: A=%02h X=%02h Y=%02h P=%h PC=%04h cycles=%0d",
                   e.tag, a_out, x_out, y_out, p_out, pc_out, cyc_now);
          chk({e.tag, "_cycles"}, cyc_now, e.cyc);
          chk({e.tag, "_A"}, a_out, e.a);
          chk({e.tag, "_X"}, x_out, e.x);
          chk({e.tag, "_Y"}, y_out, e.y);
          chk({e.tag, "_P"}, p_out, e.p);
          chk({e.tag, "_PC"}, pc_out, e.pc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    reset     = 1'b0;
    mem_ready = 1'b1;

    // 1: reset values, first fetch addresses, LDA #42
    clear_mem();
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h42;
    repeat (2) @(negedge clk);
    chk("rst_A", a_out, 8'h00);
    chk("rst_X", x_out, 8'h00);
    chk("rst_Y", y_out, 8'h00);
    chk("rst_P", p_out, 4'h0);
    chk("rst_PC", pc_out, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_done", instr_done, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    expect_instr("t1_lda_imm", 8'h42, 8'h00, 8'h00, 4'h0, 16'h0002, 3);
    reset = 1'b1;
    #1;
    chk("t1_mem_rd", mem_rd, 1'b1);
    chk("t1_addr0", mem_addr, 16'h0000);
    @(negedge clk);
    chk("t1_addr1", mem_addr, 16'h0001);
    drain(20);

    // 2: ADC carry/zero, SEC + SBC overflow
    clear_mem();
    mem[0] = 8'hA9; mem[1] = 8'hFF; mem[2] = 8'h69; mem[3] = 8'h01;
    mem[4] = 8'hA9; mem[5] = 8'h80; mem[6] = 8'h38; mem[7] = 8'hE9; mem[8] = 8'h01;
    expect_instr("t2_lda_ff",  8'hFF, 8'h00, 8'h00, 4'h8, 16'h0002, 3);
    expect_instr("t2_adc_01",  8'h00, 8'h00, 8'h00, 4'h3, 16'h0004, 3);
    expect_instr("t2_lda_80",  8'h80, 8'h00, 8'h00, 4'h9, 16'h0006, 3);
    expect_instr("t2_sec",     8'h80, 8'h00, 8'h00, 4'h9, 16'h0007, 2);
    expect_instr("t2_sbc_01",  8'h7F, 8'h00, 8'h00, 4'h5, 16'h0009, 3);
    reset = 1'b1;
    drain(60);

    // 3: abs,X with and without page cross
    clear_mem();
    mem[0] = 8'hA2; mem[1] = 8'hFF; mem[2] = 8'hBD; mem[3] = 8'h01; mem[4] = 8'h12;
    mem[5] = 8'hA2; mem[6] = 8'h01; mem[7] = 8'hBD; mem[8] = 8'h00; mem[9] = 8'h12;
    mem[16'h1300] = 8'h5A; mem[16'h1200] = 8'hEE; mem[16'h1201] = 8'h33;
    expect_instr("t3_ldx_ff",   8'h00, 8'hFF, 8'h00, 4'h8, 16'h0002, 3);
    expect_instr("t3_absx_fix", 8'h5A, 8'hFF, 8'h00, 4'h0, 16'h0005, 6);
    expect_instr("t3_ldx_01",   8'h5A, 8'h01, 8'h00, 4'h0, 16'h0007, 3);
    expect_instr("t3_absx",     8'h33, 8'h01, 8'h00, 4'h0, 16'h000A, 5);
    reset = 1'b1;
    drain(60);

    // 4: zp,X wraps in page zero; INX wraps to zero
    clear_mem();
    mem[0] = 8'hA2; mem[1] = 8'h10; mem[2] = 8'hB5; mem[3] = 8'hF8;
    mem[4] = 8'hA2; mem[5] = 8'hFF; mem[6] = 8'hE8;
    mem[16'h0008] = 8'h77; mem[16'h0108] = 8'h11;
    expect_instr("t4_ldx_10", 8'h00, 8'h10, 8'h00, 4'h0, 16'h0002, 3);
    expect_instr("t4_zpx",    8'h77, 8'h10, 8'h00, 4'h0, 16'h0004, 4);
    expect_instr("t4_ldx_ff", 8'h77, 8'hFF, 8'h00, 4'h8, 16'h0006, 3);
    expect_instr("t4_inx",    8'h77, 8'h00, 8'h00, 4'h2, 16'h0007, 2);
    reset = 1'b1;
    drain(60);

    // 5: wait states in OPLO, then reset during READ
    clear_mem();
    mem[0] = 8'hA9; mem[1] = 8'h42; mem[2] = 8'hAD; mem[3] = 8'h00; mem[4] = 8'h30;
    mem[16'h3000] = 8'h99;
    expect_instr("t5_wait_lda", 8'h42, 8'h00, 8'h00, 4'h0, 16'h0002, 6);
    reset = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_addr", mem_addr, 16'h0001);
      chk("t5_hold_rd", mem_rd, 1'b1);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && mem_addr === 16'h3000) found = 1'b1;
    end
    chk("t5_reached_read", found, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5_rd_gated", mem_rd, 1'b0);
    @(negedge clk);
    chk("t5_rst_A", a_out, 8'h00);
    chk("t5_rst_PC", pc_out, 16'h0000);
    chk("t5_rst_rd", mem_rd, 1'b0);
    chk("t5_rst_done", instr_done, 1'b0);
    chk("t5_queue_empty", sb.size(), 0);
    @(negedge clk);
    chk("t5_rst_rd2", mem_rd, 1'b0);

    // 6: unknown opcode halts and freezes state until reset
    clear_mem();
    mem[0] = 8'hA9; mem[1] = 8'h42; mem[2] = 8'h02;
    expect_instr("t6_lda", 8'h42, 8'h00, 8'h00, 4'h0, 16'h0002, 3);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (halted === 1'b1) found = 1'b1;
    end
    chk("t6_halted", found, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_halt_sticky", halted, 1'b1);
      chk("t6_halt_rd", mem_rd, 1'b0);
      chk("t6_halt_done", instr_done, 1'b0);
      chk("t6_halt_A", a_out, 8'h42);
      chk("t6_halt_PC", pc_out, 16'h0003);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_halted", halted, 1'b0);
    chk("t6_rst_PC", pc_out, 16'h0000);
    chk("t6_rst_A", a_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
